// File: rtl/acq_pkg.sv
// Shared types and helpers for the acquisition controller: one-hot state encoding
// and the masked trigger comparison.
package acq_pkg;

  localparam int unsigned NumStates = 6;
  localparam int unsigned TrigMaxW  = 64;

  typedef enum logic [NumStates-1:0] {
    StIdle    = 6'b000001,
    StPre     = 6'b000010,
    StArmed   = 6'b000100,
    StPost    = 6'b001000,
    StDone    = 6'b010000,
    StRelease = 6'b100000
  } acq_state_e;

  // Operands are zero-extended by the caller; bits outside the mask never matter.
  function automatic logic trig_match(input logic [TrigMaxW-1:0] smp,
                                      input logic [TrigMaxW-1:0] mask,
                                      input logic [TrigMaxW-1:0] value);
    return (smp & mask) == (value & mask);
  endfunction

endpackage

// File: rtl/acq_if.sv
// Sample RAM write port between the acquisition controller (master) and the RAM (slave).
interface acq_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 10
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/acq_trigger.sv
// Combinational masked trigger compare on the live probe sample.
module acq_trigger
  import acq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] sample_i,
  input  logic [WIDTH-1:0] mask_i,
  input  logic [WIDTH-1:0] value_i,
  output logic             match_o
);
  assign match_o = trig_match(TrigMaxW'(sample_i), TrigMaxW'(mask_i), TrigMaxW'(value_i));
endmodule

// File: rtl/acq_controller.sv
// One logic-analyser acquisition pass: trigger search, sample RAM writes, done pulse.
// Define PRETRIGGER_EN to enable the pre-trigger ring buffer and the PRE state.
module acq_controller
  import acq_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              grant_acq,
  output logic              done_acq,
  input  logic [WIDTH-1:0]  sample,
  input  logic [WIDTH-1:0]  trig_mask,
  input  logic [WIDTH-1:0]  trig_value,
  input  logic [ADDR_W-1:0] pre_cnt,
  acq_if.master             ram,
  output logic [ADDR_W-1:0] start_addr,
  output logic              busy,
  output logic              triggered
);
  localparam int unsigned CntW = ADDR_W + 1;
  localparam logic [CntW-1:0] Depth = {1'b1, {ADDR_W{1'b0}}};

  acq_state_e        state_q, state_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0]  wr_data_q, wr_data_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;
  logic [CntW-1:0]   wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] pre_q, pre_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0] start_addr_q, start_addr_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              trig_q, trig_d;
  logic              match;

  acq_trigger #(.WIDTH(WIDTH)) u_trigger (
    .sample_i(sample),
    .mask_i  (trig_mask),
    .value_i (trig_value),
    .match_o (match)
  );

`ifndef PRETRIGGER_EN
  logic unused_pre_cnt;
  assign unused_pre_cnt = ^pre_cnt;
`endif

  always_comb begin
    state_d      = state_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = sample;
    next_addr_d  = next_addr_q;
    wcnt_d       = wcnt_q;
    pre_d        = pre_q;
    trig_addr_d  = trig_addr_q;
    start_addr_d = start_addr_q;
    done_d       = 1'b0;
    trig_d       = trig_q;

    unique case (state_q)
      StIdle: begin
        if (grant_acq) begin
          next_addr_d  = '0;
          wcnt_d       = '0;
          trig_addr_d  = '0;
          start_addr_d = '0;
`ifdef PRETRIGGER_EN
          pre_d   = pre_cnt;
          state_d = (pre_cnt == '0) ? StArmed : StPre;
`else
          pre_d   = '0;
          state_d = StArmed;
`endif
        end
      end
      StPre: begin
        if (!grant_acq) begin
          state_d = StIdle;
        end else begin
          wr_en_d     = 1'b1;
          wr_addr_d   = next_addr_q;
          next_addr_d = next_addr_q + ADDR_W'(1);
          wcnt_d      = wcnt_q + CntW'(1);
          if (wcnt_q + CntW'(1) == {1'b0, pre_q}) state_d = StArmed;
        end
      end
      StArmed: begin
        if (!grant_acq) begin
          state_d = StIdle;
        end else if (match) begin
          wr_en_d     = 1'b1;
          wr_addr_d   = next_addr_q;
          next_addr_d = next_addr_q + ADDR_W'(1);
          trig_addr_d = next_addr_q;
          // Pre-trigger history plus the trigger sample count toward the full buffer.
          wcnt_d      = {1'b0, pre_q} + CntW'(1);
          trig_d      = 1'b1;
          state_d     = StPost;
        end
`ifdef PRETRIGGER_EN
        else begin
          wr_en_d     = 1'b1;
          wr_addr_d   = next_addr_q;
          next_addr_d = next_addr_q + ADDR_W'(1);
        end
`endif
      end
      StPost: begin
        if (!grant_acq) begin
          state_d = StIdle;
        end else if (wcnt_q == Depth) begin
          done_d       = 1'b1;
          start_addr_d = trig_addr_q - pre_q;
          state_d      = StDone;
        end else begin
          wr_en_d     = 1'b1;
          wr_addr_d   = next_addr_q;
          next_addr_d = next_addr_q + ADDR_W'(1);
          wcnt_d      = wcnt_q + CntW'(1);
        end
      end
      StDone:    state_d = StRelease;
      StRelease: if (!grant_acq) state_d = StIdle;
      default:   state_d = StIdle;
    endcase

    if (state_d == StIdle) trig_d = 1'b0;
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      next_addr_q  <= '0;
      wcnt_q       <= '0;
      pre_q        <= '0;
      trig_addr_q  <= '0;
      start_addr_q <= '0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      trig_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      next_addr_q  <= next_addr_d;
      wcnt_q       <= wcnt_d;
      pre_q        <= pre_d;
      trig_addr_q  <= trig_addr_d;
      start_addr_q <= start_addr_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      trig_q       <= trig_d;
    end
  end

  assign ram.wr_en   = wr_en_q;
  assign ram.wr_addr = wr_addr_q;
  assign ram.wr_data = wr_data_q;
  assign done_acq    = done_q;
  assign start_addr  = start_addr_q;
  assign busy        = busy_q;
  assign triggered   = trig_q;
endmodule

// File: tb/tb_acq_controller.sv
// Scoreboard bench for acq_controller (WIDTH=8, ADDR_W=4): a pass-level model queues
// expected RAM writes and done pulses; a monitor checks them as the DUT produces them.
module tb_acq_controller;
  localparam int Depth = 16;
`ifdef PRETRIGGER_EN
  localparam bit PreTrig = 1'b1;
`else
  localparam bit PreTrig = 1'b0;
`endif

  typedef struct {
    int         cyc;
    logic [3:0] addr;
    logic [7:0] data;
    logic       trig;
  } wr_exp_t;

  typedef struct {
    int         cyc;
    logic [3:0] start;
  } done_exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       grant;
  logic       done_acq;
  logic [7:0] sample;
  logic [7:0] trig_mask;
  logic [7:0] trig_value;
  logic [3:0] pre_cnt;
  logic [3:0] start_addr;
  logic       busy;
  logic       triggered;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  wr_exp_t   wr_q[$];
  done_exp_t done_q[$];

  acq_if #(.WIDTH(8), .ADDR_W(4)) ram_if ();

  acq_controller #(.WIDTH(8), .ADDR_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .grant_acq (grant),
    .done_acq  (done_acq),
    .sample    (sample),
    .trig_mask (trig_mask),
    .trig_value(trig_value),
    .pre_cnt   (pre_cnt),
    .ram       (ram_if),
    .start_addr(start_addr),
    .busy      (busy),
    .triggered (triggered)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT writes or signals done.
  wr_exp_t   me;
  done_exp_t md;
  always @(posedge clk) begin
    #1;
    if (ram_if.wr_en) begin
      if (wr_q.size() == 0) begin
        chk("unexpected_write", 32'(ram_if.wr_addr), 32'hFFFF_FFFF);
      end else begin
        me = wr_q.pop_front();
        chk("write_cycle", cyc, me.cyc);
        chk("write_addr", 32'(ram_if.wr_addr), 32'(me.addr));
        chk("write_data", 32'(ram_if.wr_data), 32'(me.data));
        chk("write_triggered", 32'(triggered), 32'(me.trig));
      end
    end else if (wr_q.size() > 0 && wr_q[0].cyc <= cyc) begin
      me = wr_q.pop_front();
      chk("missing_write", 32'(ram_if.wr_en), 32'd1);
    end
    if (done_acq) begin
      if (done_q.size() == 0) begin
        chk("unexpected_done", 32'(done_acq), 32'd0);
      end else begin
        md = done_q.pop_front();
        chk("done_cycle", cyc, md.cyc);
        chk("start_addr", 32'(start_addr), 32'(md.start));
        chk("done_triggered", 32'(triggered), 32'd1);
        chk("done_busy", 32'(busy), 32'd1);
      end
    end else if (done_q.size() > 0 && done_q[0].cyc <= cyc) begin
      md = done_q.pop_front();
      chk("missing_done", 32'(done_acq), 32'd1);
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr_en"}, 32'(ram_if.wr_en), 32'd0);
    chk({tag, "_wr_addr"}, 32'(ram_if.wr_addr), 32'd0);
    chk({tag, "_wr_data"}, 32'(ram_if.wr_data), 32'd0);
    chk({tag, "_done"}, 32'(done_acq), 32'd0);
    chk({tag, "_start"}, 32'(start_addr), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_trig"}, 32'(triggered), 32'd0);
  endtask

  // One grant: samples are planned up front, the model derives every write from them.
  // do_stop ends the pass early (grant drop, or reset if use_rst) at sample index
  // trigger_index + off; that sample is still driven in the same cycle.
  task automatic run_pass(input int pre, input logic [7:0] mask, input logic [7:0] value,
                          input int nomatch, input int trig_s, input bit do_stop,
                          input int off, input bit use_rst);
    logic [7:0] smp[$];
    logic [7:0] s;
    int p_eff, t_idx, n, g;
    p_eff = PreTrig ? pre : 0;
    if (mask == 8'h00) nomatch = 0;
    for (int i = 0; i < p_eff; i++) smp.push_back(8'($urandom));
    for (int i = 0; i < nomatch; i++) begin
      do s = 8'($urandom); while ((s & mask) == (value & mask));
      smp.push_back(s);
    end
    if (trig_s >= 0) s = 8'(trig_s);
    else s = (8'($urandom) & ~mask) | (value & mask);
    t_idx = smp.size();
    smp.push_back(s);
    for (int i = 0; i < Depth - 1 - p_eff; i++) smp.push_back(8'($urandom));
    n = do_stop ? t_idx + off : smp.size();

    @(negedge clk);
    g          = cyc + 1;
    grant      = 1'b1;
    pre_cnt    = 4'(pre);
    trig_mask  = mask;
    trig_value = value;
    sample     = 8'($urandom);

    for (int i = 0; i < n; i++) begin
      if (PreTrig || i >= t_idx)
        wr_q.push_back('{cyc: g + 1 + i,
                         addr: PreTrig ? 4'(i) : 4'(i - t_idx),
                         data: smp[i],
                         trig: (i >= t_idx)});
    end
    if (!do_stop)
      done_q.push_back('{cyc: g + 1 + smp.size(), start: PreTrig ? 4'(t_idx - p_eff) : 4'd0});

    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sample = smp[i];
    end
    @(negedge clk);
    if (do_stop) begin
      if (n < smp.size()) sample = smp[n];
      grant = 1'b0;
      if (use_rst) begin
        rst = 1'b1;
        #1;
        chk_all_zero("mid_reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
      end
    end else begin
      @(negedge clk);
      grant = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_triggered", 32'(triggered), 32'd0);
    chk("idle_wr_en", 32'(ram_if.wr_en), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    grant      = 1'b0;
    sample     = 8'h00;
    trig_mask  = 8'h00;
    trig_value = 8'h00;
    pre_cnt    = 4'd0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_busy", 32'(busy), 32'd0);

    run_pass(0, 8'h00, 8'h00, 0, -1, 1'b0, 0, 1'b0);    // immediate trigger, full capture
    run_pass(0, 8'h0F, 8'h05, 20, 8'h35, 1'b0, 0, 1'b0); // trigger on 0x35 after 20 misses
    run_pass(4, 8'hF0, 8'hA0, 26, -1, 1'b0, 0, 1'b0);    // pre=4: trig_addr 14, start 10
    run_pass(0, 8'hFF, 8'h3C, 12, -1, 1'b1, -5, 1'b0);   // grant drop while armed
    run_pass(0, 8'h00, 8'h00, 0, -1, 1'b0, 0, 1'b0);     // next grant restarts at addr 0
    run_pass(3, 8'h81, 8'h01, 6, -1, 1'b1, 0, 1'b0);     // drop coincides with trigger
    run_pass(15, 8'h0F, 8'h0A, 5, -1, 1'b0, 0, 1'b0);    // pre = DEPTH-1
    run_pass(2, 8'hFF, 8'h55, 7, -1, 1'b1, 6, 1'b1);     // reset mid-POST
    run_pass(0, 8'h3C, 8'h14, 3, -1, 1'b0, 0, 1'b0);     // pass right after reset

    for (int k = 0; k < 8; k++) begin
      logic [7:0] m;
      m = (k % 4 == 0) ? 8'h00 : 8'($urandom);
      run_pass(int'($urandom_range(0, 15)), m, 8'($urandom), int'($urandom_range(0, 25)),
               -1, 1'b0, 0, 1'b0);
    end

    repeat (5) @(negedge clk);
    chk("pending_writes", wr_q.size(), 32'd0);
    chk("pending_dones", done_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
